// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain half of an async FIFO: binary/Gray write pointer, read-pointer
// synchroniser and registered full / almost_full / occupancy / overflow flags.
module fifo_wr_ptr_ctrl #(
  parameter int ADDR        = 5,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 30
) (
  input  logic            wclk,
  input  logic            wrst_n,
  input  logic            winc,
  input  logic            ovf_clr,
  input  logic [ADDR:0]   rptr_gray_async,
  output logic            wen,
  output logic [ADDR-1:0] waddr,
  output logic [ADDR:0]   wptr,
  output logic [ADDR:0]   wptr_gray,
  output logic            full,
  output logic            almost_full,
  output logic [ADDR:0]   wcount,
  output logic            overflow
);

  localparam logic [ADDR:0] AF_VAL = (ADDR+1)'(AF_THRESH);

  function automatic logic [ADDR:0] bin2gray(input logic [ADDR:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR:0] gray2bin(input logic [ADDR:0] g);
    logic [ADDR:0] b;
    b = g;
    for (int i = ADDR - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR:0] wptr_r;
  logic [ADDR:0] wptr_gray_r;
  logic [ADDR:0] wcount_r;
  logic          full_r;
  logic          almost_full_r;
  logic          overflow_r;
  logic [ADDR:0] rsync_r [SYNC_STAGES];

  logic          wen_s;
  logic [ADDR:0] wptr_next_s;
  logic [ADDR:0] rbin_s;
  logic [ADDR:0] wcount_next_s;
  logic          full_next_s;
  logic          ovf_next_s;

  // Next-state pointer, occupancy and flag equations; all flags use the post-write pointer
  always_comb begin
    wen_s         = winc & ~full_r;
    wptr_next_s   = wptr_r + {{ADDR{1'b0}}, wen_s};
    rbin_s        = gray2bin(rsync_r[SYNC_STAGES-1]);
    wcount_next_s = wptr_next_s - rbin_s;
    full_next_s   = (wptr_next_s[ADDR] != rbin_s[ADDR]) &&
                    (wptr_next_s[ADDR-1:0] == rbin_s[ADDR-1:0]);
    // A rejected write always sets; it outranks a same-cycle clear
    if (winc && full_r) begin
      ovf_next_s = 1'b1;
    end else if (ovf_clr) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = overflow_r;
    end
  end

  // Read Gray pointer synchroniser chain
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rsync_r[i] <= {(ADDR+1){1'b0}};
      end
    end else begin
      rsync_r[0] <= rptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rsync_r[i] <= rsync_r[i-1];
      end
    end
  end

  // Pointer, occupancy and flag registers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_r        <= {(ADDR+1){1'b0}};
      wptr_gray_r   <= {(ADDR+1){1'b0}};
      wcount_r      <= {(ADDR+1){1'b0}};
      full_r        <= 1'b0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      wptr_r        <= wptr_next_s;
      wptr_gray_r   <= bin2gray(wptr_next_s);
      wcount_r      <= wcount_next_s;
      full_r        <= full_next_s;
      almost_full_r <= (wcount_next_s >= AF_VAL);
      overflow_r    <= ovf_next_s;
    end
  end

  assign wen         = wen_s;
  assign waddr       = wptr_r[ADDR-1:0];
  assign wptr        = wptr_r;
  assign wptr_gray   = wptr_gray_r;
  assign full        = full_r;
  assign almost_full = almost_full_r;
  assign wcount      = wcount_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Scoreboard bench for fifo_wr_ptr_ctrl: an integer write/read-count model
// predicts every cycle's outputs; a monitor compares them one cycle at a time.
module tb_fifo_wr_ptr_ctrl;

  localparam int ADDR  = 5;
  localparam int DEPTH = 32;
  localparam int SYNC  = 2;
  localparam int AF    = 30;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [5:0] rptr_gray_async = 6'd0;
  logic       wen;
  logic [4:0] waddr;
  logic [5:0] wptr;
  logic [5:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [5:0] wcount;
  logic       overflow;

  fifo_wr_ptr_ctrl #(.ADDR(ADDR), .SYNC_STAGES(SYNC), .AF_THRESH(AF)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .ovf_clr(ovf_clr),
    .rptr_gray_async(rptr_gray_async), .wen(wen), .waddr(waddr), .wptr(wptr),
    .wptr_gray(wptr_gray), .full(full), .almost_full(almost_full),
    .wcount(wcount), .overflow(overflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [5:0] wptr;
    logic [5:0] gray;
    logic [5:0] cnt;
    logic       full;
    logic       af;
    logic       ovf;
    logic       wen;
  } exp_t;

  exp_t sb[$];
  int   rdq[$];
  int   checks = 0;
  int   failures = 0;
  int   m_wr = 0;
  int   rd_total = 0;
  bit   m_full = 1'b0;
  bit   m_ovf = 1'b0;
  bit   full_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = 0;
    m_full = 1'b0;
    m_ovf = 1'b0;
    rdq.delete();
    sb.delete();
    for (int i = 0; i < SYNC; i++) rdq.push_back(0);
  endtask

  // Reference model: occupancy = accepted writes minus read count seen SYNC edges ago
  initial begin
    int   seen;
    int   occ;
    bit   acc;
    exp_t e;
    model_reset();
    forever begin
      @(posedge wclk or negedge wrst_n);
      if (!wrst_n) begin
        model_reset();
      end else begin
        seen = rdq.pop_front();
        rdq.push_back(rd_total);
        acc = winc && !m_full;
        m_ovf = (winc && m_full) ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
        m_wr = m_wr + int'(acc);
        occ = m_wr - seen;
        m_full = (occ == DEPTH);
        e.wptr = 6'(m_wr % (2 * DEPTH));
        e.gray = e.wptr ^ (e.wptr >> 1);
        e.cnt  = 6'(occ);
        e.full = m_full;
        e.af   = (occ >= AF);
        e.ovf  = m_ovf;
        e.wen  = winc && !m_full;
        sb.push_back(e);
      end
    end
  end

  // Monitor: compare DUT outputs against the oldest prediction each cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge wclk);
      #1;
      if (wrst_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("mon_wptr", 32'(wptr), 32'(e.wptr));
        chk("mon_gray", 32'(wptr_gray), 32'(e.gray));
        chk("mon_waddr", 32'(waddr), 32'(e.wptr[4:0]));
        chk("mon_wcount", 32'(wcount), 32'(e.cnt));
        chk("mon_full", 32'(full), 32'(e.full));
        chk("mon_af", 32'(almost_full), 32'(e.af));
        chk("mon_ovf", 32'(overflow), 32'(e.ovf));
        chk("mon_wen", 32'(wen), 32'(e.wen));
      end
    end
  end

  task automatic step(input bit w, input bit c, input bit ri);
    logic [5:0] b;
    @(negedge wclk);
    winc = w;
    ovf_clr = c;
    if (ri) rd_total++;
    b = rd_total[5:0];
    rptr_gray_async = b ^ (b >> 1);
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst_n = 1'b0;
    rd_total = 0;
    rptr_gray_async = 6'd0;
    winc = 1'b0;
    ovf_clr = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Asynchronous reset in the middle of a clock phase
    repeat (9) step(1'b1, 1'b0, 1'b0);
    chk("pre_rst_wptr", 32'(wptr), 32'd9);
    #2;
    wrst_n = 1'b0;
    rd_total = 0;
    rptr_gray_async = 6'd0;
    winc = 1'b0;
    #1;
    chk("rst_wptr", 32'(wptr), 32'd0);
    chk("rst_gray", 32'(wptr_gray), 32'd0);
    chk("rst_wcount", 32'(wcount), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Fill to DEPTH with the reader parked at 0
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == AF - 1) chk("fill_af_below", 32'(almost_full), 32'd0);
      if (i == AF) chk("fill_af_at", 32'(almost_full), 32'd1);
      if (i == DEPTH - 1) chk("fill_full_early", 32'(full), 32'd0);
    end
    chk("fill_wptr", 32'(wptr), 32'h20);
    chk("fill_gray", 32'(wptr_gray), 32'h30);
    chk("fill_wcount", 32'(wcount), 32'd32);
    chk("fill_full", 32'(full), 32'd1);

    // Overflow set, clear, and set-beats-clear
    step(1'b1, 1'b0, 1'b0);
    chk("ovf_wen", 32'(wen), 32'd0);
    chk("ovf_wptr_hold", 32'(wptr), 32'h20);
    chk("ovf_set", 32'(overflow), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("ovf_clr", 32'(overflow), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("ovf_wptr_hold2", 32'(wptr), 32'h20);

    // Read-side release reaches full on the third edge
    step(1'b0, 1'b0, 1'b1);
    chk("rel_full_e1", 32'(full), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("rel_full_e2", 32'(full), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("rel_full_e3", 32'(full), 32'd0);
    chk("rel_wcount", 32'(wcount), 32'd31);

    // Write coinciding with the synchronised read advance
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("sim_wcount", 32'(wcount), 32'd31);
    chk("sim_full", 32'(full), 32'd0);
    chk("sim_wptr", 32'(wptr), 32'd33);

    // Wrap: 70 writes with the reader trailing by 4
    do_reset();
    full_seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step(1'b1, 1'b0, (m_wr >= 4) && (rd_total < m_wr - 4));
      if (full) full_seen = 1'b1;
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("wrap_wptr", 32'(wptr), 32'd6);
    chk("wrap_wcount", 32'(wcount), 32'd4);
    chk("wrap_no_full", 32'(full_seen), 32'd0);

    // Random traffic: slow reader first (fills, overflows), then fast reader
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 8,
           (rd_total < m_wr) && ($urandom_range(0, 99) < ((n < 1500) ? 40 : 85)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ptr_ctrl.md
Name: fifo_wr_ptr_ctrl

Overview:
Write-side pointer and flag controller for the asynchronous FIFO, in the write clock domain, directly upstream of the write-full comparator.
- Maintains the binary write pointer (ADDR+1 bits, MSB = wrap bit) and its Gray-coded copy for crossing into the read domain.
- Synchronizes the read pointer's Gray copy into the write domain.
- Produces registered full/almost_full, the occupancy count, memory write address/enable, and a sticky overflow flag.

Parameters:
ADDR, 5, memory address width; DEPTH = 2**ADDR entries; pointers are ADDR+1 bits
SYNC_STAGES, 2, flop stages on incoming read Gray pointer (legal 2..4)
AF_THRESH, 30, almost_full asserts when occupancy >= AF_THRESH (legal 1..DEPTH)

Ports:
wclk  input  1  write-domain clock, rising edge
wrst_n  input  1  asynchronous active-low reset, write domain
winc  input  1  write request from producer
ovf_clr  input  1  clears sticky overflow
rptr_gray_async  input  ADDR+1  read pointer, Gray-coded, launched from read domain
wen  output  1  memory write enable = winc & ~full (combinational)
waddr  output  ADDR  memory write address = wptr[ADDR-1:0]
wptr  output  ADDR+1  binary write pointer (registered)
wptr_gray  output  ADDR+1  Gray write pointer, registered, to read-domain synchronizer
full  output  1  registered full flag
almost_full  output  1  registered occupancy >= AF_THRESH
wcount  output  ADDR+1  registered occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full

Behaviour:
- Reset (wrst_n low, asynchronous):
  - wptr, wptr_gray, wcount, all sync flops = 0.
  - full = 0, almost_full = 0 (unless AF_THRESH would be met at 0; not legal), overflow = 0.
  - Release is sampled on the first rising wclk edge after deassertion.
- Write acceptance: a write is accepted on a wclk edge when wen = 1.
  - wptr_next = wptr + wen, modulo 2**(ADDR+1).
  - wptr and wptr_gray = wptr_next ^ (wptr_next >> 1) update on that edge.
  - wptr_gray is therefore glitch-free, with one bit changing per increment.
- Read pointer synchronization:
  - rptr_gray_async passes through a SYNC_STAGES flop chain.
  - The last stage is converted Gray->binary combinationally to rbin (bit i = XOR of bits ADDR..i).
- full_next = (wptr_next[ADDR] != rbin[ADDR]) && (wptr_next[ADDR-1:0] == rbin[ADDR-1:0]); registered into full.
  - full asserts on the same edge the DEPTH-th outstanding write is accepted; no write is lost.
- wcount_next = (wptr_next - rbin) mod 2**(ADDR+1); registered into wcount.
  - almost_full = registered (wcount_next >= AF_THRESH).
- Latency of read-side release: a change on rptr_gray_async is reflected in full/wcount/almost_full on the (SYNC_STAGES+1)th rising edge.
  - Flags are pessimistic: full may stay high extra cycles; it never deasserts early.
- Overflow:
  - Set on any edge with winc = 1 && full = 1.
  - Cleared by ovf_clr = 1; simultaneous set and clear -> set wins.
  - Pointer does not move on a rejected write.
- Wrap-around: wptr rolls from 2**(ADDR+1)-1 to 0; the MSB toggles every DEPTH writes.
- Simultaneous write accept and read-pointer advance in the same cycle: both are applied in the next-state equations; wcount stays correct.
- Reset mid-operation: all state clears immediately, independent of wclk.
  - The read domain must be reset concurrently; behaviour with only one side reset is undefined.

Test Plan:
- Reset: assert wrst_n=0 mid-clock with wptr=6'd9 -> wptr, wptr_gray, wcount=0, full=0, overflow=0 immediately, no clock edge needed.
- Fill: ADDR=5, rptr_gray_async=0, winc=1 for 32 cycles -> after the 32nd edge wptr=6'b100000, wptr_gray=6'b110000, wcount=32, full=1; almost_full=1 from the 30th edge.
- Overflow: continue winc=1 while full -> wen=0, wptr holds 6'b100000, overflow=1. Pulse ovf_clr with winc=0 -> overflow=0. ovf_clr=1 with winc=1 while full -> overflow stays 1.
- Release latency: from full, drive rptr_gray_async=6'b000001 -> full stays 1 for 2 edges, drops to 0 on the 3rd edge (SYNC_STAGES=2), wcount=31.
- Wrap: interleave writes with a read pointer trailing by 4, for 70 writes -> wptr=6'd6 after wrapping through 63->0, wcount=4, full never asserts.
- Simultaneous: wcount=31, same cycle as a write, rptr advances by 1 (after sync) -> wcount remains 31, full=0.
